brief_kp_packer: RTL and testbench

Downstream stage of the 9-line/6-pixel keypoint-flag delay in the ORB BRIEF path. It receives the delayed 1-bit keypoint flag, aligned to the BRIEF window centre, together with the parallel descriptor bits computed on the same pixel strobe. On each keypoint it tags the descriptor with the keypoint's image coordinate and buffers it. Buffered keypoints leave as fixed-length word packets on a valid/ready stream toward the matcher/DMA.

---
 rtl/brief_pkg.sv | 31 +++
 rtl/brief_kp_fifo.sv | 63 ++++++
 rtl/brief_kp_packer.sv | 184 ++++++++++++++++++
 tb/tb_brief_kp_packer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/brief_pkg.sv
// Shared types and defaults for the BRIEF keypoint packer: buffered entry layout,
// serializer states and the header word format.
package brief_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int X_OFS_DEF = 6;
    localparam int Y_OFS_DEF = 9;
    localparam int DESC_BITS = 256;
    localparam int WORD_W    = 32;
    localparam int COORD_W   = 16;
    localparam int N_DESC_WORDS = DESC_BITS / WORD_W;

    typedef struct packed {
        logic [COORD_W-1:0]   y;
        logic [COORD_W-1:0]   x;
        logic [DESC_BITS-1:0] desc;
    } kp_entry_t;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_HDR  = 2'd1,
        SER_DESC = 2'd2
    } ser_state_e;

    function automatic logic [WORD_W-1:0] pack_header(input logic [COORD_W-1:0] y,
                                                      input logic [COORD_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/brief_kp_fifo.sv
// Synchronous keypoint FIFO; full/empty are registered from the occupancy count
// so they carry no combinational path back from push/pop.
module brief_kp_fifo
    import brief_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  kp_entry_t i_data,
    input  logic      i_pop,
    output kp_entry_t o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);

    kp_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    assign do_push = i_push && !full_q;
    assign do_pop  = i_pop && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: occupancy is governed by the pointers alone.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: rtl/brief_kp_packer.sv
// Tags each keypoint descriptor with its window-centre coordinate, buffers it and
// streams it out as a header word followed by the descriptor words, LSB word first.
module brief_kp_packer
    import brief_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int X_OFS      = X_OFS_DEF,
    parameter int Y_OFS      = Y_OFS_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_frame_start,
    input  logic                 i_kp,
    input  logic [DESC_BITS-1:0] i_desc,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WORD_W-1:0]    o_data,
    output logic                 o_last,
    output logic [15:0]          o_drop_cnt,
    output logic                 o_overflow,
    output ser_state_e           o_dbg_state
);

    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int IDXW = (N_DESC_WORDS > 1) ? $clog2(N_DESC_WORDS) : 1;

    logic [XW-1:0] x_q, x_d, cur_x, kp_x;
    logic [YW-1:0] y_q, y_d, cur_y, kp_y;
    logic          fs, borrow, y_uflow, push, drop;
    logic [15:0]   drop_cnt_q, drop_cnt_d, drop_base;
    logic          ovf_q, ovf_d, ovf_base;

    kp_entry_t     push_entry, head;
    logic          fifo_full, fifo_empty, pop;

    assign fs = i_en && i_frame_start;

    always_comb begin
        cur_x = fs ? '0 : x_q;
        cur_y = fs ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (i_en) begin
            if (cur_x == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    // Window centre trails the stream; x wraps into the previous line with a borrow.
    always_comb begin
        borrow  = (cur_x < XW'(X_OFS));
        kp_x    = borrow ? cur_x + XW'(IMG_W - X_OFS) : cur_x - XW'(X_OFS);
        y_uflow = ({1'b0, cur_y} < ((YW+1)'(Y_OFS) + (YW+1)'(borrow)));
        kp_y    = cur_y - YW'(Y_OFS) - YW'(borrow);
        push    = i_en && i_kp && !y_uflow && !fifo_full;
        drop    = i_en && i_kp && (y_uflow || fifo_full);
        push_entry.y    = COORD_W'(kp_y);
        push_entry.x    = COORD_W'(kp_x);
        push_entry.desc = i_desc;
    end

    always_comb begin
        drop_base  = fs ? '0 : drop_cnt_q;
        ovf_base   = fs ? 1'b0 : ovf_q;
        drop_cnt_d = drop_base;
        ovf_d      = ovf_base;
        if (drop) begin
            if (drop_base != 16'hFFFF) drop_cnt_d = drop_base + 1'b1;
            ovf_d = 1'b1;
        end
    end

    brief_kp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (push_entry),
        .i_pop   (pop),
        .o_data  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Stream handshake: a word moves on any edge where o_valid && i_ready; while
    // o_valid is high without i_ready, o_data/o_last hold and o_valid stays high.
    ser_state_e        state_q, state_d;
    kp_entry_t         entry_q, entry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              valid_q, valid_d, last_q, last_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              xfer, load;

    assign xfer = valid_q && i_ready;

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        load    = 1'b0;
        case (state_q)
            SER_IDLE: load = !fifo_empty;
            SER_HDR: begin
                if (xfer) begin
                    idx_d   = '0;
                    data_d  = entry_q.desc[0 +: WORD_W];
                    last_d  = (N_DESC_WORDS == 1);
                    state_d = SER_DESC;
                end
            end
            SER_DESC: begin
                if (xfer) begin
                    if (last_q) begin
                        load = !fifo_empty;
                        if (fifo_empty) begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            state_d = SER_IDLE;
                        end
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = entry_q.desc[WORD_W*idx_d +: WORD_W];
                        last_d = (idx_d == IDXW'(N_DESC_WORDS - 1));
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
        // Loading straight from the final-word handshake keeps packets back-to-back.
        if (load) begin
            entry_d = head;
            data_d  = pack_header(head.y, head.x);
            valid_d = 1'b1;
            last_d  = 1'b0;
            state_d = SER_HDR;
        end
        pop = load;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            state_q    <= SER_IDLE;
            entry_q    <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            entry_q    <= entry_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_last      = last_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_overflow  = ovf_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_brief_kp_packer.sv
// Directed bench for brief_kp_packer: coordinate tagging, drops, back-pressure,
// packet ordering against an expected-word queue, and mid-packet reset.
module tb_brief_kp_packer;
    import brief_pkg::*;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic                 i_en = 1'b0;
    logic                 i_frame_start = 1'b0;
    logic                 i_kp = 1'b0;
    logic [DESC_BITS-1:0] i_desc = '0;
    logic                 i_ready = 1'b0;
    logic                 o_valid, o_last, o_overflow;
    logic [WORD_W-1:0]    o_data;
    logic [15:0]          o_drop_cnt;
    ser_state_e           o_dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [WORD_W-1:0] exp_q[$];
    logic              exp_last_q[$];
    int sx = 0, sy = 0;
    bit mon_en = 0, rand_ready = 0;
    int word_cnt = 0, last_cnt = 0;
    logic stall_pend = 1'b0;
    logic [WORD_W-1:0] held_data = '0;
    logic held_last = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time expired, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    brief_kp_packer dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (i_en),
        .i_frame_start (i_frame_start),
        .i_kp          (i_kp),
        .i_desc        (i_desc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_last        (o_last),
        .o_drop_cnt    (o_drop_cnt),
        .o_overflow    (o_overflow),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pix(input logic kp, input logic fs, input logic [DESC_BITS-1:0] d);
        i_en = 1'b1; i_kp = kp; i_frame_start = fs; i_desc = d;
        @(posedge i_clk); #1;
        i_en = 1'b0; i_kp = 1'b0; i_frame_start = 1'b0;
        if (fs) begin
            sx = 1; sy = 0;
        end else begin
            sx++;
            if (sx == 640) begin
                sx = 0;
                sy = (sy == 479) ? 0 : sy + 1;
            end
        end
    endtask

    task automatic goto_pos(input int tx, input int ty);
        while (!(sx == tx && sy == ty)) pix(1'b0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    function automatic logic [DESC_BITS-1:0] mk_desc(input int n);
        logic [DESC_BITS-1:0] d;
        d = '0;
        for (int k = 0; k < N_DESC_WORDS; k++) d[WORD_W*k +: WORD_W] = {16'(n), 8'hD5, 8'(k)};
        return d;
    endfunction

    task automatic expect_pkt(input logic [WORD_W-1:0] hdr, input logic [DESC_BITS-1:0] d);
        exp_q.push_back(hdr);
        exp_last_q.push_back(1'b0);
        for (int k = 0; k < N_DESC_WORDS; k++) begin
            exp_q.push_back(d[WORD_W*k +: WORD_W]);
            exp_last_q.push_back(k == N_DESC_WORDS - 1);
        end
    endtask

    task automatic wait_drain(input int budget, output int cycles);
        cycles = 0;
        while ((exp_q.size() != 0 || o_valid) && cycles < budget) begin
            @(posedge i_clk); #1;
            cycles++;
        end
        check("drain", 64'(exp_q.size()) + 64'(o_valid), 64'd0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    initial forever begin
        @(negedge i_clk);
        if (mon_en) begin
            if (stall_pend) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_data, held_data);
                check("stall_last", o_last, held_last);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("word", o_data, exp_q.pop_front());
                    check("last", o_last, exp_last_q.pop_front());
                end
                word_cnt++;
                if (o_last) last_cnt++;
            end
            stall_pend = o_valid && !i_ready;
            held_data  = o_data;
            held_last  = o_last;
        end
    end

    initial forever begin
        @(posedge i_clk); #1;
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- directed sequence ----------------
    logic [DESC_BITS-1:0] d1, d2, d;
    int cyc;

    initial begin
        d1 = 256'h0123456789abcdef_fedcba9876543210_deadbeefcafef00d_1122334455667788;
        d2 = mk_desc(99);
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_last", o_last, 0);
        check("rst_drop", o_drop_cnt, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_state", o_dbg_state, SER_IDLE);
        mon_en = 1;

        // Frame 1: y underflow drop, x borrow, latency
        pix(1'b0, 1'b1, '0);
        goto_pos(10, 5);
        pix(1'b1, 1'b0, d1);
        check("uflow_drop", o_drop_cnt, 1);
        check("uflow_ovf", o_overflow, 1);
        idle(4);
        check("uflow_no_pkt", o_valid, 0);

        goto_pos(2, 18);
        expect_pkt(32'h0008_027C, d2);
        pix(1'b1, 1'b0, d2);

        goto_pos(20, 18);
        expect_pkt(32'h0009_000E, d1);
        pix(1'b1, 1'b0, d1);
        @(negedge i_clk);
        check("lat_t1_valid", o_valid, 0);
        @(negedge i_clk);
        check("lat_t2_valid", o_valid, 1);
        check("lat_t2_hdr", o_data, 32'h0009_000E);
        @(posedge i_clk); #1;
        wait_drain(40, cyc);
        check("f1_drop", o_drop_cnt, 1);

        // Frame 2: frame start clears stats; FIFO overflow under stall
        pix(1'b0, 1'b1, '0);
        check("fs_clr_drop", o_drop_cnt, 0);
        check("fs_clr_ovf", o_overflow, 0);
        i_ready = 1'b0;
        goto_pos(100, 10);
        for (int i = 0; i < 10; i++) begin
            d = mk_desc(i);
            if (i < 9) expect_pkt(32'h0001_005E + 32'(i), d);
            pix(1'b1, 1'b0, d);
        end
        check("full_drop", o_drop_cnt, 1);
        check("full_ovf", o_overflow, 1);
        check("stall_state", o_dbg_state, SER_HDR);
        check("stall_hdr", o_data, 32'h0001_005E);
        word_cnt = 0;
        last_cnt = 0;
        i_ready = 1'b1;
        wait_drain(200, cyc);
        check("burst_words", word_cnt, 81);
        check("burst_lasts", last_cnt, 9);
        check("burst_cycles", cyc, 81);

        // Random back-pressure
        rand_ready = 1;
        for (int i = 0; i < 6; i++) begin
            goto_pos(200 + 15*i, 10);
            d = mk_desc(16 + i);
            expect_pkt(32'h0001_00C2 + 32'(15*i), d);
            pix(1'b1, 1'b0, d);
        end
        wait_drain(600, cyc);
        rand_ready = 0;
        idle(1);
        i_ready = 1'b1;
        check("rand_drop", o_drop_cnt, 1);

        // Reset in the middle of a packet with a second keypoint buffered
        mon_en = 0;
        goto_pos(30, 12);
        pix(1'b1, 1'b0, mk_desc(40));
        pix(1'b1, 1'b0, mk_desc(41));
        idle(3);
        check("pre_rst_state", o_dbg_state, SER_DESC);
        i_rst_n = 1'b0;
        #1;
        check("rst2_valid", o_valid, 0);
        check("rst2_last", o_last, 0);
        check("rst2_state", o_dbg_state, SER_IDLE);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        sx = 0; sy = 0;
        exp_q.delete();
        exp_last_q.delete();
        stall_pend = 1'b0;
        idle(5);
        check("post_rst_empty", o_valid, 0);
        mon_en = 1;

        // Frame 3: keypoint coincident with frame start is dropped; clean packet after
        pix(1'b1, 1'b1, d1);
        check("fs_kp_drop", o_drop_cnt, 1);
        check("fs_kp_ovf", o_overflow, 1);
        idle(3);
        check("fs_kp_no_pkt", o_valid, 0);
        goto_pos(30, 12);
        expect_pkt(32'h0003_0018, d2);
        pix(1'b1, 1'b0, d2);
        wait_drain(40, cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
